// File: rtl/custom_acc_pkg.sv
// Shared constants, output-register state encoding and sizing helper
// for the partial-sum accumulator.
package custom_acc_pkg;

    localparam int unsigned N_TERMS_DEF = 9;
    localparam int unsigned ACC_W_DEF   = 16;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_e;

    // Counter width for 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/custom_acc_out_reg.sv
// Single-entry holding register for a finished window sum plus its
// overflow flag, presented on a valid/ready port.
module custom_acc_out_reg
    import custom_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_data,
    input  logic             load_ovf,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    out_state_e state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (load) state_nxt = HOLD;
            HOLD:  if (out_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (load) begin
            out_data <= load_data;
            out_ovf  <= load_ovf;
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: rtl/custom_psum_accumulator.sv
// Accumulates N_TERMS unsigned products per window and hands each finished
// sum to a holding register so the next window can start under backpressure.
module custom_psum_accumulator
    import custom_acc_pkg::*;
#(
    parameter int unsigned N_TERMS = N_TERMS_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       mul_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned      CNT_W = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             completing;

    // Only the completing term has to wait for the holding register to drain
    assign in_ready   = !clear && !(out_valid && count == LAST);
    assign accept     = in_valid && in_ready;
    assign completing = accept && (count == LAST);
    assign sum        = (ACC_W+1)'(acc) + (ACC_W+1)'(mul_in);

    always_comb begin
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        count_nxt = count;
        if (clear || completing) begin
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            count_nxt = '0;
        end else if (accept) begin
            acc_nxt   = sum[ACC_W-1:0];
            ovf_nxt   = ovf | sum[ACC_W];
            count_nxt = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            count <= count_nxt;
            busy  <= (count_nxt != '0);
        end
    end

    custom_acc_out_reg #(
        .ACC_W (ACC_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (completing),
        .load_data (sum[ACC_W-1:0]),
        .load_ovf  (ovf | sum[ACC_W]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

endmodule

// File: tb/tb_custom_psum_accumulator.sv
// Directed bench for the partial-sum accumulator: three instances (defaults,
// narrow accumulator, single-term window) share stimulus, each checked alone.
module tb_custom_psum_accumulator;

    logic clk = 1'b0;
    logic rst, clear, in_valid, out_ready;
    logic [7:0] mul_in;

    logic        in_ready0, out_valid0, out_ovf0, busy0;
    logic [15:0] out_data0;
    logic        in_ready1, out_valid1, out_ovf1, busy1;
    logic [9:0]  out_data1;
    logic        in_ready2, out_valid2, out_ovf2, busy2;
    logic [15:0] out_data2;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    custom_psum_accumulator u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .mul_in(mul_in), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ovf(out_ovf0), .busy(busy0)
    );

    custom_psum_accumulator #(.N_TERMS(9), .ACC_W(10)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .mul_in(mul_in), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ovf(out_ovf1), .busy(busy1)
    );

    custom_psum_accumulator #(.N_TERMS(1), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
        .mul_in(mul_in), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_ovf(out_ovf2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return in_ready0;
            1:       return in_ready1;
            default: return in_ready2;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mul_in = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one product to instance sel and wait (bounded) for acceptance
    task automatic send(input int sel, input logic [7:0] v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        mul_in   = v;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("send_timeout", 32'(rdy(sel)), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();

        // Reset values
        check("rst_in_ready",  32'(in_ready0),  32'd1);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_out_data",  32'(out_data0),  32'd0);
        check("rst_out_ovf",   32'(out_ovf0),   32'd0);
        check("rst_busy",      32'(busy0),      32'd0);

        // 9 x 3 = 27
        for (int i = 0; i < 9; i++) begin
            send(0, 8'd3);
            if (i == 3) check("busy_mid", 32'(busy0), 32'd1);
        end
        check("w27_valid", 32'(out_valid0), 32'd1);
        check("w27_data",  32'(out_data0),  32'd27);
        check("w27_ovf",   32'(out_ovf0),   32'd0);
        check("w27_busy",  32'(busy0),      32'd0);

        // ACC_W=10 wrap: 9 x 255 = 2295 -> 247 with overflow, then 9 x 1
        do_reset();
        for (int i = 0; i < 9; i++) send(1, 8'd255);
        check("w10_valid", 32'(out_valid1), 32'd1);
        check("w10_data",  32'(out_data1),  32'd247);
        check("w10_ovf",   32'(out_ovf1),   32'd1);
        for (int i = 0; i < 9; i++) send(1, 8'd1);
        check("w10b_data", 32'(out_data1),  32'd9);
        check("w10b_ovf",  32'(out_ovf1),   32'd0);

        // Backpressure: windows of 1s and 2s with out_ready low
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 8'd1);
        check("bp_first_valid", 32'(out_valid0), 32'd1);
        check("bp_first_data",  32'(out_data0),  32'd9);
        for (int i = 0; i < 8; i++) begin
            check("bp_ready_during", 32'(in_ready0), 32'd1);
            send(0, 8'd2);
        end
        check("bp_stall_ready", 32'(in_ready0),  32'd0);
        check("bp_held_data",   32'(out_data0),  32'd9);
        @(negedge clk);
        check("bp_stable_data", 32'(out_data0),  32'd9);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_pop_valid", 32'(out_valid0), 32'd0);
        check("bp_pop_ready", 32'(in_ready0),  32'd1);
        send(0, 8'd2);
        check("bp_second_valid", 32'(out_valid0), 32'd1);
        check("bp_second_data",  32'(out_data0),  32'd18);
        out_ready = 1'b1;

        // clear after 4 of 5 drops the partial window and the clear-cycle product
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 8'd5);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; mul_in = 8'd100;
        #1;
        check("clr_in_ready", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clr_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 9; i++) send(0, 8'd2);
        check("clr_data", 32'(out_data0), 32'd18);

        // N_TERMS=1 with out_ready toggling
        do_reset();
        out_ready = 1'b0;
        send(2, 8'd7);
        check("n1_valid7", 32'(out_valid2), 32'd1);
        check("n1_data7",  32'(out_data2),  32'd7);
        check("n1_ready",  32'(in_ready2),  32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("n1_pop_valid", 32'(out_valid2), 32'd0);
        check("n1_pop_ready", 32'(in_ready2),  32'd1);
        send(2, 8'd8);
        check("n1_data8", 32'(out_data2), 32'd8);
        out_ready = 1'b1;

        // Asynchronous reset mid-window and during HOLD
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 8'd4);
        check("ar_busy_before", 32'(busy0), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_mid_busy",  32'(busy0),      32'd0);
        check("ar_mid_ready", 32'(in_ready0),  32'd1);
        check("ar_mid_valid", 32'(out_valid0), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 8'd4);
        check("ar_hold_data", 32'(out_data0), 32'd36);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_hold_valid", 32'(out_valid0), 32'd0);
        check("ar_hold_data0", 32'(out_data0),  32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(0, 8'd4);
        check("ar_after_valid", 32'(out_valid0), 32'd1);
        check("ar_after_data",  32'(out_data0),  32'd36);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/custom_psum_accumulator.md
# custom_psum_accumulator

Downstream partial-sum stage for the feature/weight buffer-and-multiply stage. Consumes the 8-bit unsigned product stream, accumulates exactly N_TERMS products per window (one convolution output point), and presents the finished sum on a valid/ready output port. A holding register decouples output backpressure from accumulation of the next window.

## Interface
- N_TERMS, 9: products per window, ≥1 (9 = 3x3 kernel)
- ACC_W, 16: accumulator and output width, ≥8
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous abort of the current window
- in_valid  input  1  mul_in holds a product
- in_ready  output  1  stage accepts a product this cycle
- mul_in  input  8  unsigned product from the multiply stage
- out_valid  output  1  out_data/out_ovf hold a finished window
- out_ready  input  1  consumer takes the result
- out_data  output  ACC_W  window sum, modulo 2^ACC_W
- out_ovf  output  1  carry out of ACC_W occurred during this window
- busy  output  1  window in progress (count ≠ 0)

## Operation
- Accept = in_valid && in_ready at a rising edge.
- mul_in zero-extended to ACC_W; acc wraps modulo 2^ACC_W; any carry-out sets the window's sticky ovf bit.
- Counter count in 0..N_TERMS-1, width $clog2(N_TERMS), min 1 bit.
- Accept with count < N_TERMS-1: acc += mul_in, count += 1.
- Accept with count == N_TERMS-1 (completing): out_data ← acc + mul_in, out_ovf ← sticky ovf | this carry, out_valid ← 1; acc, ovf, count ← 0.
- Output register states: EMPTY (out_valid=0), HOLD (out_valid=1).
  - EMPTY → HOLD on completing accept.
  - HOLD → EMPTY on out_valid && out_ready.
- in_ready = !clear && !(out_valid && count == N_TERMS-1). No combinational path from out_ready or in_valid to in_ready.
- Accumulation continues while HOLD; only the completing term stalls.
- clear: acc, ovf, count ← 0 at the edge. Any product on mul_in that cycle is dropped, since in_ready=0. Output register and out_valid are unaffected.
- N_TERMS=1: every accept is completing; in_ready=0 whenever out_valid=1.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0; acc=0, count=0.

## Timing
- Latency: the completing accept at edge k gives out_valid=1 and valid out_data after edge k.
- Throughput: one product per cycle while out_ready is held high.
- With out_ready low through the next window, exactly one bubble: in_ready=0 until the cycle after the pop.
- Pop and completing accept can never coincide, because in_ready blocks the completing term while HOLD.
- out_data and out_ovf are stable while out_valid=1 && out_ready=0.
- rst asserted mid-window or in HOLD: all state returns to reset values immediately, independent of clk. The partial window and any held result are discarded.
- busy is registered and equals (count ≠ 0).

## Structure
- Shared package custom_acc_pkg holds:
  - default constants N_TERMS_DEF=9, ACC_W_DEF=16
  - output state enum {EMPTY, HOLD}
  - count-width helper function
- Natural sub-module: custom_acc_out_reg. It is the ACC_W+1-bit output holding register with out_valid/out_ready logic, load enable and asynchronous rst.
- Top level holds the accumulator, sticky ovf bit, counter and in_ready logic.

## Test plan
- Defaults, 9 accepts of mul_in=3, out_ready=1 → one cycle after the 9th accept: out_valid=1, out_data=27, out_ovf=0, busy=0.
- ACC_W=10, 9 accepts of 255 → out_data=247 (2295 mod 1024), out_ovf=1. Next window of 9×1 → out_data=9, out_ovf=0.
- Back-to-back windows of 1 and 2, out_ready held low → results stay 9 then 18 in order. in_ready=0 only on the 18th term until the first pop. No product lost or duplicated.
- clear after 4 terms of 5, then 9 terms of 2 → out_data=18. A product presented with clear high is not counted.
- N_TERMS=1, mul_in 7,8 with out_ready toggling → out_data 7 then 8. in_ready deasserts while HOLD.
- rst pulsed asynchronously mid-window (count=5) and again during HOLD → outputs return to reset values without a clock edge. A following full window of 9×4 gives out_data=36.
